// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the sysid check controller.
// SYSID_TS_CHECK_EN makes the timestamp part of the pass decision.
package sysid_check_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ID,
    S_RD_TS,
    S_EVAL,
    S_FIN
  } state_t;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  localparam logic [31:0] DEF_EXPECTED_ID = 32'd291;
  localparam logic [31:0] DEF_EXPECTED_TS = 32'd1435585823;
  localparam int DEF_TIMEOUT_CYCLES = 16;
  localparam int DEF_MAX_RETRIES = 2;

`ifdef SYSID_TS_CHECK_EN
  localparam bit TS_CHECK = 1'b1;
`else
  localparam bit TS_CHECK = 1'b0;
`endif

endpackage

// File: rtl/sysid_rd_timeout.sv
// Stall counter for one Avalon read; expired fires on the last
// stalled cycle allowed before the read is abandoned.
module sysid_rd_timeout #(
  parameter int LIMIT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [15:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign expired = enable && (cnt == 16'(LIMIT - 1));

endmodule

// File: rtl/sysid_check_ctrl.sv
// Avalon-MM reader that confirms the sysid ID/timestamp words.
// SYSID_TS_CHECK_EN: timestamp must also match for a pass.
module sysid_check_ctrl
  import sysid_check_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEF_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEF_EXPECTED_TS,
  parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int          MAX_RETRIES    = DEF_MAX_RETRIES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [3:0]  retry_cnt
);

  state_t state;
  logic   accept;
  logic   stalled;
  logic   expired;
  logic   id_ok;
  logic   ts_ok;
  logic   att_ok;

  assign accept  = avm_read && !avm_waitrequest;
  assign stalled = avm_read && avm_waitrequest;

  sysid_rd_timeout #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_tmo (
    .clock  (clock),
    .reset  (reset),
    .clear  (!stalled),
    .enable (stalled),
    .expired(expired)
  );

  assign id_ok  = id_value == EXPECTED_ID;
  assign ts_ok  = !TS_CHECK || (ts_value == EXPECTED_TS);
  assign att_ok = !timeout_err && id_ok && ts_ok;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      avm_address <= ADDR_ID;
      avm_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout_err <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
      retry_cnt   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_RD_ID;
            busy        <= 1'b1;
            pass        <= 1'b0;
            timeout_err <= 1'b0;
            retry_cnt   <= '0;
            avm_read    <= 1'b1;
            avm_address <= ADDR_ID;
          end
        end
        S_RD_ID: begin
          if (accept) begin
            id_value    <= avm_readdata;
            avm_address <= ADDR_TS;
            state       <= S_RD_TS;
          end else if (expired) begin
            avm_read    <= 1'b0;
            timeout_err <= 1'b1;
            state       <= S_EVAL;
          end
        end
        S_RD_TS: begin
          if (accept) begin
            ts_value <= avm_readdata;
            avm_read <= 1'b0;
            state    <= S_EVAL;
          end else if (expired) begin
            avm_read    <= 1'b0;
            timeout_err <= 1'b1;
            state       <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (att_ok) begin
            pass  <= 1'b1;
            done  <= 1'b1;
            state <= S_FIN;
          end else if (retry_cnt < 4'(MAX_RETRIES)) begin
            retry_cnt   <= retry_cnt + 4'd1;
            timeout_err <= 1'b0;
            avm_read    <= 1'b1;
            avm_address <= ADDR_ID;
            state       <= S_RD_ID;
          end else begin
            pass  <= 1'b0;
            done  <= 1'b1;
            state <= S_FIN;
          end
        end
        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Randomized bench for sysid_check_ctrl with an attempt-level
// reference model and a programmable stalling sysid slave.
module tb_sysid_check_ctrl;

  localparam logic [31:0] EXP_ID = 32'd291;
  localparam logic [31:0] EXP_TS = 32'd1435585823;
  localparam int TO = 16;
  localparam int MR = 2;
`ifdef SYSID_TS_CHECK_EN
  localparam bit TS_ON = 1'b1;
`else
  localparam bit TS_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout_err;
  logic [31:0] id_value;
  logic [31:0] ts_value;
  logic [3:0]  retry_cnt;

  int n_chk = 0;
  int n_err = 0;

  sysid_check_ctrl #(
    .EXPECTED_ID   (EXP_ID),
    .EXPECTED_TS   (EXP_TS),
    .TIMEOUT_CYCLES(TO),
    .MAX_RETRIES   (MR)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .timeout_err    (timeout_err),
    .id_value       (id_value),
    .ts_value       (ts_value),
    .retry_cnt      (retry_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // per-attempt slave behaviour: stall cycles per address and data
  int          stall_tbl[MR+1][2];
  logic [31:0] id_tbl[MR+1];
  logic [31:0] ts_tbl[MR+1];
  int          att = -1;
  int          st_cnt = 0;
  int          sa;
  bit          last_acc = 1'b0;
  bit          prev_read = 1'b0;
  bit          prev_stall = 1'b0;
  logic        prev_addr = 1'b0;

  always @(negedge clock) begin
    if (reset || !avm_read) begin
      avm_waitrequest = 1'b0;
      st_cnt = 0;
      last_acc = 1'b0;
    end else begin
      if (!prev_read) begin
        att++;
        st_cnt = 0;
      end else if (last_acc) begin
        st_cnt = 0;
      end
      if (prev_read && prev_stall)
        check("addr_hold", 32'(avm_address), 32'(prev_addr));
      sa = (att > MR) ? MR : ((att < 0) ? 0 : att);
      if (st_cnt < stall_tbl[sa][avm_address]) begin
        avm_waitrequest = 1'b1;
        st_cnt++;
        last_acc = 1'b0;
      end else begin
        avm_waitrequest = 1'b0;
        avm_readdata = avm_address ? ts_tbl[sa] : id_tbl[sa];
        last_acc = 1'b1;
      end
    end
    prev_read  = avm_read && !reset;
    prev_stall = avm_waitrequest;
    prev_addr  = avm_address;
  end

  logic [31:0] m_id = '0;
  logic [31:0] m_ts = '0;

  task automatic fill(input int s_id, input int s_ts,
                      input logic [31:0] idw, input logic [31:0] tsw);
    for (int a = 0; a <= MR; a++) begin
      stall_tbl[a][0] = s_id;
      stall_tbl[a][1] = s_ts;
      id_tbl[a] = idw;
      ts_tbl[a] = tsw;
    end
  endtask

  function automatic int rnd_stall();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 5) return 0;
    if (r < 8) return int'($urandom_range(1, 6));
    if (r == 8) return TO - 1;
    return TO + int'($urandom_range(0, 3));
  endfunction

  task automatic randomize_tbl();
    for (int a = 0; a <= MR; a++) begin
      stall_tbl[a][0] = rnd_stall();
      stall_tbl[a][1] = rnd_stall();
      id_tbl[a] = ($urandom_range(0, 3) != 0) ? EXP_ID : $urandom;
      ts_tbl[a] = ($urandom_range(0, 3) != 0) ? EXP_TS : $urandom;
    end
  endtask

  // model whole attempts, then run the DUT and compare
  task automatic run_seq(input bit extra_start);
    int          len = 0;
    int          cyc;
    int          e_att = 0;
    int          e_ret = 0;
    bit          to;
    bit          ok;
    bit          e_pass = 1'b0;
    bit          e_to = 1'b0;
    logic [31:0] e_id = m_id;
    logic [31:0] e_ts = m_ts;

    for (int a = 0; a <= MR; a++) begin
      e_att++;
      to = 1'b0;
      if (stall_tbl[a][0] >= TO) begin
        len += TO;
        to = 1'b1;
      end else begin
        len += stall_tbl[a][0] + 1;
        e_id = id_tbl[a];
        if (stall_tbl[a][1] >= TO) begin
          len += TO;
          to = 1'b1;
        end else begin
          len += stall_tbl[a][1] + 1;
          e_ts = ts_tbl[a];
        end
      end
      len += 1;
      ok = !to && (e_id == EXP_ID) && (!TS_ON || (e_ts == EXP_TS));
      if (ok || a == MR) begin
        e_pass = ok;
        e_to = to;
        e_ret = a;
        break;
      end
    end

    att = -1;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 1;
    check("busy_on", 32'(busy), 32'd1);
    while (!done && cyc < 300) begin
      @(negedge clock);
      cyc++;
      start = (extra_start && cyc == 2);
    end
    start = 1'b0;
    check("latency", 32'(cyc), 32'(len + 1));
    check("pass", 32'(pass), 32'(e_pass));
    check("timeout_err", 32'(timeout_err), 32'(e_to));
    check("retry_cnt", 32'(retry_cnt), 32'(e_ret));
    check("id_value", id_value, e_id);
    check("ts_value", ts_value, e_ts);
    check("attempts", 32'(att + 1), 32'(e_att));
    @(negedge clock);
    check("done_pulse", 32'(done), 32'd0);
    check("busy_off", 32'(busy), 32'd0);
    repeat (3) @(negedge clock);
    check("idle_read", 32'(avm_read), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("hold_pass", 32'(pass), 32'(e_pass));
    m_id = e_id;
    m_ts = e_ts;
  endtask

  initial begin
    fill(0, 0, EXP_ID, EXP_TS);
    repeat (3) @(negedge clock);
    check("rst_read", 32'(avm_read), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_to", 32'(timeout_err), 32'd0);
    check("rst_id", id_value, 32'd0);
    check("rst_ts", ts_value, 32'd0);
    check("rst_retry", 32'(retry_cnt), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    fill(0, 0, EXP_ID, EXP_TS);
    run_seq(1'b0);
    fill(0, 0, 32'd292, EXP_TS);
    run_seq(1'b0);
    fill(1000, 0, EXP_ID, EXP_TS);
    run_seq(1'b0);
    fill(0, 0, EXP_ID, 32'd0);
    run_seq(1'b0);
    fill(0, 0, EXP_ID, EXP_TS);
    stall_tbl[0][0] = 5;
    run_seq(1'b1);

    // reset while the timestamp read is in flight
    fill(0, 0, EXP_ID, EXP_TS);
    att = -1;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    check("rd_ts_read", 32'(avm_read), 32'd1);
    check("rd_ts_addr", 32'(avm_address), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("arst_read", 32'(avm_read), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_id", id_value, 32'd0);
    check("arst_retry", 32'(retry_cnt), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    m_id = '0;
    m_ts = '0;
    repeat (2) @(negedge clock);
    check("arst_idle", 32'(busy), 32'd0);

    for (int i = 0; i < 40; i++) begin
      randomize_tbl();
      run_seq(($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sysid_check_ctrl.md
Name: sysid_check_ctrl

Overview:
- Avalon-MM read master that sequences the system-ID slave: reads ID word (address 0), then timestamp word (address 1), and compares both against expected build constants.
- Sits between the boot/reset sequencer and the sysid slave. Gates software start until the hardware image is confirmed.
- Provides retry, per-access timeout, and sticky pass/fail status.

Parameters:
- EXPECTED_ID, 32'd291, expected word at address 0.
- EXPECTED_TS, 32'd1435585823, expected word at address 1.
- TIMEOUT_CYCLES, 16, maximum cycles avm_read may stay stalled by waitrequest; 1..65535.
- MAX_RETRIES, 2, extra full sequences attempted after a mismatch or timeout; 0..15.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- start  in  1  single-cycle pulse; begins a check sequence. Ignored while busy.
- avm_address  out  1  word address to sysid slave.
- avm_read  out  1  read strobe.
- avm_waitrequest  in  1  slave stall; tie 0 for the zero-wait sysid.
- avm_readdata  in  32  read data; valid in the cycle where avm_read=1 and avm_waitrequest=0.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse at sequence end.
- pass  out  1  sticky result: ID matched (and TS, see Optional Feature).
- timeout_err  out  1  sticky; last attempt ended in a timeout.
- id_value  out  32  last captured ID word.
- ts_value  out  32  last captured timestamp word.
- retry_cnt  out  4  retries consumed in the current/last sequence.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; timeout counter 0.
- States: IDLE, RD_ID, RD_TS, EVAL, FIN.
- IDLE:
  - start=1 moves to RD_ID.
  - Clears pass, timeout_err, and retry_cnt.
  - busy=1 from the next cycle.
- RD_ID:
  - Drives avm_read=1 and avm_address=0. Both are held stable while waitrequest=1.
  - On accept, captures id_value and goes to RD_TS.
  - Minimum latency with waitrequest=0 is 1 cycle per read.
- RD_TS: same handshake with address=1; captures ts_value, then goes to EVAL.
- Timeout:
  - The counter increments each cycle a read is stalled and resets on every accept.
  - When it reaches TIMEOUT_CYCLES-1 while still stalled, avm_read drops the next cycle, timeout_err is set, and the FSM goes to EVAL as a failed attempt.
- EVAL (1 cycle): the attempt passes if there was no timeout and id_value==EXPECTED_ID.
  - Pass: pass=1, go to FIN.
  - Fail with retry_cnt<MAX_RETRIES: retry_cnt++, timeout_err cleared, go to RD_ID.
  - Fail with retry_cnt==MAX_RETRIES: pass=0, go to FIN.
- FIN (1 cycle): done=1, busy=0 next cycle, return to IDLE.
- Total latency with no stalls and a first-attempt pass: start to done is 4 cycles.
- start during busy: ignored, with no queuing.
- Reset mid-operation: the read strobe drops immediately (asynchronous) and all status clears.
- Result registers hold until the next accepted start.

Optional Feature:
- Macro: SYSID_TS_CHECK_EN.
- Defined: EVAL additionally requires ts_value==EXPECTED_TS for a pass.
- Undefined: ts_value is captured and reported but ignored for the pass decision.

Decomposition:
- Package sysid_check_pkg holds:
  - FSM state enum;
  - address constants ADDR_ID=1'b0 and ADDR_TS=1'b1;
  - default expected-value constants.
- One natural sub-module, sysid_rd_timeout: stall counter with clear/enable inputs and an expired output.

Test Plan:
- Zero-wait slave returns 291/1435585823; pulse start → done after 4 cycles; pass=1; id_value=291; retry_cnt=0.
- Slave returns ID 292 always, MAX_RETRIES=2 → 3 full sequences observed; done; pass=0; retry_cnt=2; timeout_err=0.
- waitrequest held high, TIMEOUT_CYCLES=16 → read drops after 16 stalled cycles; after 3 attempts pass=0 and timeout_err=1.
- Timestamp 0 with ID 291 → pass=1 without SYSID_TS_CHECK_EN; with the macro, pass=0 after the retries.
- waitrequest high 5 cycles on the first read only → address/read held stable; done at cycle 9; pass=1.
- Assert reset while in RD_TS, and pulse start during busy → avm_read=0 and outputs 0 immediately after reset; the extra start causes no second sequence.
